// File: rtl/hs_fifo_pkt_arb_pkg.sv
`default_nettype none
// ============================================================================
// hs_fifo_pkt_arb_pkg : shared FSM state encoding and round-robin pointer width
// Rev 1.0
// ============================================================================
package hs_fifo_pkt_arb_pkg;

    localparam int c_MAX_SRC = 8;
    localparam int PTR_W     = $clog2(c_MAX_SRC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
        ST_FLUSH = 2'd2,
`endif
        ST_LOCK  = 2'd1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/hs_fifo_rr_pick.sv
`default_nettype none
// ============================================================================
// hs_fifo_rr_pick : combinational round-robin winner search from i_ptr+1
// Rev 1.0
// ============================================================================
module hs_fifo_rr_pick
    import hs_fifo_pkt_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_grant,
    output logic               o_any
);

    int w_best_d;
    int w_best_i;

    // Distance from the slot after i_ptr; the smallest requesting distance wins.
    always_comb begin
        w_best_d = NUM_SRC;
        w_best_i = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_req[i] && (((i + NUM_SRC - 1 - int'(i_ptr)) % NUM_SRC) < w_best_d)) begin
                w_best_d = (i + NUM_SRC - 1 - int'(i_ptr)) % NUM_SRC;
                w_best_i = i;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            o_grant[i] = (w_best_d < NUM_SRC) && (w_best_i == i);
        end
        o_any = |i_req;
    end

endmodule
`default_nettype wire

// File: rtl/hs_fifo_pkt_arb.sv
`default_nettype none
// ============================================================================
// hs_fifo_pkt_arb : packet-locked round-robin arbiter onto one FIFO write port
// Optional stall watchdog / flush beat: HS_FIFO_PKT_ARB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module hs_fifo_pkt_arb
    import hs_fifo_pkt_arb_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic [NUM_SRC-1:0]              s_valid,
    output logic [NUM_SRC-1:0]              s_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_SRC-1:0]              s_last,
    input  logic [NUM_SRC-1:0]              s_drop,
    output logic                            m_wvalid,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    output logic                            m_wlast,
    output logic                            m_wdrop,
    input  logic                            m_wready,
    input  logic                            m_walmost_full,
    output logic [NUM_SRC-1:0]              grant,
    output logic                            busy
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
    ,
    output logic [NUM_SRC-1:0]              timeout
`endif
);

    localparam logic [PTR_W-1:0] c_PTR_RST = PTR_W'(NUM_SRC - 1);

    if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("hs_fifo_pkt_arb: parameter out of legal range");
    end

    arb_state_e                 r_state;
    logic [NUM_SRC-1:0]         r_grant;
    logic                       r_busy;
    logic [PTR_W-1:0]           r_ptr;
    logic [NUM_SRC-1:0]         w_pick;
    logic                       w_any;
    logic                       w_gvalid;
    logic                       w_glast;
    logic                       w_gdrop;
    logic [DATA_WIDTH-1:0]      w_gdata;
    logic [PTR_W-1:0]           w_gidx;
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
    logic [7:0]                 r_cnt;
    logic [NUM_SRC-1:0]         r_timeout;
`endif

    hs_fifo_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .i_req   (s_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // One-hot grant mux of the owner's beat signals.
    always_comb begin
        w_gdata = '0;
        w_gidx  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_gdata = w_gdata | (s_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
            if (r_grant[i]) begin
                w_gidx = PTR_W'(i);
            end
        end
        w_gvalid = |(s_valid & r_grant);
        w_glast  = |(s_last  & r_grant);
        w_gdrop  = |(s_drop  & r_grant);
    end

    always_comb begin
        m_wvalid = 1'b0;
        m_wdata  = '0;
        m_wlast  = 1'b0;
        m_wdrop  = 1'b0;
        s_ready  = '0;
        if (r_state == ST_LOCK) begin
            m_wvalid = w_gvalid;
            m_wdata  = w_gdata;
            m_wlast  = w_glast;
            m_wdrop  = w_gdrop;
            s_ready  = r_grant & {NUM_SRC{m_wready}};
        end
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
        else if (r_state == ST_FLUSH) begin
            m_wvalid = 1'b1;
            m_wlast  = 1'b1;
            m_wdrop  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= c_PTR_RST;
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= '0;
`endif
        end else begin
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
            r_timeout <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // Almost-full only gates new grants; a locked packet runs to completion.
                    if (!m_walmost_full && w_any) begin
                        r_grant <= w_pick;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_gvalid && m_wready && w_glast) begin
                        r_ptr   <= w_gidx;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
                    if (w_gvalid) begin
                        r_cnt <= '0;
                    end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_FLUSH;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
                ST_FLUSH: begin
                    if (m_wready) begin
                        r_timeout <= r_grant;
                        r_ptr     <= w_gidx;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
    assign timeout = r_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_fifo_pkt_arb.sv
`default_nettype none
// ============================================================================
// tb_hs_fifo_pkt_arb : directed vector table plus hand sequences for hs_fifo_pkt_arb
// Rev 1.0
// ============================================================================
module tb_hs_fifo_pkt_arb;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [3:0]   s_valid, s_ready, s_last, s_drop, grant;
    logic [127:0] s_data;
    logic         m_wvalid, m_wlast, m_wdrop, m_wready, m_walmost_full, busy;
    logic [31:0]  m_wdata;
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
    logic [3:0]   timeout;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    hs_fifo_pkt_arb #(
        .NUM_SRC        (4),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_drop         (s_drop),
        .m_wvalid       (m_wvalid),
        .m_wdata        (m_wdata),
        .m_wlast        (m_wlast),
        .m_wdrop        (m_wdrop),
        .m_wready       (m_wready),
        .m_walmost_full (m_walmost_full),
        .grant          (grant),
        .busy           (busy)
`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
        ,
        .timeout        (timeout)
`endif
    );

    typedef struct {
        logic [3:0]   v;
        logic [127:0] d;
        logic [3:0]   l;
        logic [3:0]   dr;
        logic         wr;
        logic         af;
        logic         rn;
        logic [3:0]   eg;
        logic         ewv;
        logic [31:0]  ewd;
        logic         ewl;
        logic         ewdr;
        logic [3:0]   esr;
    } vec_t;

    vec_t vq[$];

    function automatic logic [127:0] mk(input logic [7:0] b3, input logic [7:0] b2,
                                        input logic [7:0] b1, input logic [7:0] b0);
        return {24'h0, b3, 24'h0, b2, 24'h0, b1, 24'h0, b0};
    endfunction

    task automatic add(input logic [3:0] v, input logic [127:0] d, input logic [3:0] l,
                       input logic [3:0] dr, input logic wr, input logic af, input logic rn,
                       input logic [3:0] eg, input logic ewv, input logic [7:0] ewd,
                       input logic ewl, input logic ewdr, input logic [3:0] esr);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.dr = dr; t.wr = wr; t.af = af; t.rn = rn;
        t.eg = eg; t.ewv = ewv; t.ewd = {24'h0, ewd}; t.ewl = ewl; t.ewdr = ewdr; t.esr = esr;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [127:0] d, input logic [3:0] l,
                         input logic [3:0] dr, input logic wr, input logic af, input logic rn);
        s_valid = v; s_data = d; s_last = l; s_drop = dr;
        m_wready = wr; m_walmost_full = af; aresetn = rn;
    endtask

    initial begin
        bit found;
        drive(4'h0, '0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // v0..v13: four 2-beat packets in round-robin order; drop flag on a non-last beat
        add(4'h0, '0,                         4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'hF, mk(8'h30,8'h20,8'h10,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'hF, mk(8'h30,8'h20,8'h10,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h1, 1, 8'h00, 0, 0, 4'h1);
        add(4'hF, mk(8'h30,8'h20,8'h10,8'h01), 4'h1, 4'h0, 1, 0, 1, 4'h1, 1, 8'h01, 1, 0, 4'h1);
        add(4'hE, mk(8'h30,8'h20,8'h10,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'hE, mk(8'h30,8'h20,8'h10,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h2, 1, 8'h10, 0, 0, 4'h2);
        add(4'hE, mk(8'h30,8'h20,8'h11,8'h00), 4'h2, 4'h0, 1, 0, 1, 4'h2, 1, 8'h11, 1, 0, 4'h2);
        add(4'hC, mk(8'h30,8'h20,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'hC, mk(8'h30,8'h20,8'h00,8'h00), 4'h0, 4'h4, 1, 0, 1, 4'h4, 1, 8'h20, 0, 1, 4'h4);
        add(4'hC, mk(8'h30,8'h21,8'h00,8'h00), 4'h4, 4'h0, 1, 0, 1, 4'h4, 1, 8'h21, 1, 0, 4'h4);
        add(4'h8, mk(8'h30,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h8, mk(8'h30,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h8, 1, 8'h30, 0, 0, 4'h8);
        add(4'h8, mk(8'h31,8'h00,8'h00,8'h00), 4'h8, 4'h0, 1, 0, 1, 4'h8, 1, 8'h31, 1, 0, 4'h8);
        add(4'h0, '0,                         4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        // v14..v19: single-beat packets from 0 and 1 alternate, one beat per two cycles
        for (int k = 0; k < 3; k++) begin
            add(4'h3, mk(8'h00,8'h00,8'h41,8'h40), 4'h3, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
            add(4'h3, mk(8'h00,8'h00,8'h41,8'h40), 4'h3, 4'h0, 1, 0, 1,
                (k == 1) ? 4'h2 : 4'h1, 1, (k == 1) ? 8'h41 : 8'h40, 1, 0, (k == 1) ? 4'h2 : 4'h1);
        end
        // v20..v27: almost-full rises while source 2 is locked; source 1 waits
        add(4'h0, '0,                         4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h4, mk(8'h00,8'h50,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h6, mk(8'h00,8'h50,8'h60,8'h00), 4'h0, 4'h0, 1, 1, 1, 4'h4, 1, 8'h50, 0, 0, 4'h4);
        add(4'h6, mk(8'h00,8'h51,8'h60,8'h00), 4'h4, 4'h0, 1, 1, 1, 4'h4, 1, 8'h51, 1, 0, 4'h4);
        add(4'h2, mk(8'h00,8'h00,8'h60,8'h00), 4'h0, 4'h0, 1, 1, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h2, mk(8'h00,8'h00,8'h60,8'h00), 4'h0, 4'h0, 1, 1, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h2, mk(8'h00,8'h00,8'h60,8'h00), 4'h2, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h2, mk(8'h00,8'h00,8'h60,8'h00), 4'h2, 4'h0, 1, 0, 1, 4'h2, 1, 8'h60, 1, 0, 4'h2);
        // v28..v36: 4-beat packet from source 3 under toggling m_wready
        add(4'h8, mk(8'h70,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h8, mk(8'h70,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h8, 1, 8'h70, 0, 0, 4'h8);
        add(4'h8, mk(8'h71,8'h00,8'h00,8'h00), 4'h0, 4'h0, 0, 0, 1, 4'h8, 1, 8'h71, 0, 0, 4'h0);
        add(4'h8, mk(8'h71,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h8, 1, 8'h71, 0, 0, 4'h8);
        add(4'h8, mk(8'h72,8'h00,8'h00,8'h00), 4'h0, 4'h0, 0, 0, 1, 4'h8, 1, 8'h72, 0, 0, 4'h0);
        add(4'h8, mk(8'h72,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h8, 1, 8'h72, 0, 0, 4'h8);
        add(4'h8, mk(8'h73,8'h00,8'h00,8'h00), 4'h8, 4'h0, 0, 0, 1, 4'h8, 1, 8'h73, 1, 0, 4'h0);
        add(4'h8, mk(8'h73,8'h00,8'h00,8'h00), 4'h8, 4'h0, 1, 0, 1, 4'h8, 1, 8'h73, 1, 0, 4'h8);
        add(4'h0, '0,                         4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        // v37..v42: owner drops s_valid mid-packet and keeps the lock
        add(4'h1, mk(8'h00,8'h00,8'h00,8'h80), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h1, mk(8'h00,8'h00,8'h00,8'h80), 4'h0, 4'h0, 1, 0, 1, 4'h1, 1, 8'h80, 0, 0, 4'h1);
        add(4'h0, mk(8'h00,8'h00,8'h00,8'h81), 4'h0, 4'h0, 1, 0, 1, 4'h1, 0, 8'h00, 0, 0, 4'h1);
        add(4'h3, mk(8'h00,8'h00,8'h90,8'h81), 4'h1, 4'h0, 1, 0, 1, 4'h1, 1, 8'h81, 1, 0, 4'h1);
        add(4'h2, mk(8'h00,8'h00,8'h90,8'h00), 4'h2, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h2, mk(8'h00,8'h00,8'h90,8'h00), 4'h2, 4'h0, 1, 0, 1, 4'h2, 1, 8'h90, 1, 0, 4'h2);
        // v43..v50: reset during beat 2 of source 3, then source 0 wins
        add(4'h8, mk(8'hA0,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h8, mk(8'hA0,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 1, 4'h8, 1, 8'hA0, 0, 0, 4'h8);
        add(4'h8, mk(8'hA1,8'h00,8'h00,8'h00), 4'h0, 4'h0, 1, 0, 0, 4'h8, 1, 8'hA1, 0, 0, 4'h8);
        add(4'h9, mk(8'hA0,8'h00,8'h00,8'hB0), 4'h1, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h9, mk(8'hA0,8'h00,8'h00,8'hB0), 4'h1, 4'h0, 1, 0, 1, 4'h1, 1, 8'hB0, 1, 0, 4'h1);
        add(4'h8, mk(8'hA0,8'h00,8'h00,8'h00), 4'h8, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);
        add(4'h8, mk(8'hA0,8'h00,8'h00,8'h00), 4'h8, 4'h0, 1, 0, 1, 4'h8, 1, 8'hA0, 1, 0, 4'h8);
        add(4'h0, '0,                         4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0);

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].d, vq[i].l, vq[i].dr, vq[i].wr, vq[i].af, vq[i].rn);
            @(negedge clk);
            chk($sformatf("v%0d grant", i),   {28'h0, grant},   {28'h0, vq[i].eg});
            chk($sformatf("v%0d busy", i),    {31'h0, busy},    {31'h0, |vq[i].eg});
            chk($sformatf("v%0d wvalid", i),  {31'h0, m_wvalid}, {31'h0, vq[i].ewv});
            chk($sformatf("v%0d s_ready", i), {28'h0, s_ready}, {28'h0, vq[i].esr});
            if (vq[i].ewv) begin
                chk($sformatf("v%0d wdata", i), m_wdata, vq[i].ewd);
                chk($sformatf("v%0d wlast", i), {31'h0, m_wlast}, {31'h0, vq[i].ewl});
                chk($sformatf("v%0d wdrop", i), {31'h0, m_wdrop}, {31'h0, vq[i].ewdr});
            end
            @(posedge clk);
            #1;
        end

        // Bounded wait for a lone request from source 2
        drive(4'h4, mk(8'h00,8'hE0,8'h00,8'h00), 4'h4, 4'h0, 1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            if (grant == 4'h4) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("lone grant seen", {31'h0, found}, 32'h1);
        chk("lone wdata", m_wdata, 32'hE0);
        @(posedge clk);
        #1;
        drive(4'h0, '0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("lone release", {28'h0, grant}, 32'h0);

`ifdef HS_FIFO_PKT_ARB_TIMEOUT_EN
        @(posedge clk);
        #1;
        drive(4'h6, mk(8'h00,8'hD0,8'hC0,8'h00), 4'h4, 4'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("to grant1", {28'h0, grant}, 32'h2);
        chk("to beat1", m_wdata, 32'hC0);
        @(posedge clk);
        #1;
        s_valid = 4'h4;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("to stall%0d", k), {27'h0, grant, m_wvalid}, {27'h0, 4'h2, 1'b0});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("flush ctl", {28'h0, m_wvalid, m_wlast, m_wdrop, |s_ready}, 32'hE);
        chk("flush data", m_wdata, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("timeout pulse", {28'h0, timeout}, 32'h2);
        chk("flush idle", {28'h0, grant}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post-timeout grant", {28'h0, grant}, 32'h4);
        chk("timeout cleared", {28'h0, timeout}, 32'h0);
        @(posedge clk);
        #1;
        drive(4'h0, '0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs_fifo_pkt_arb.md
HS_FIFO_PKT_ARB -- requirements
Module: hs_fifo_pkt_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of requesters, legal range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, beat payload width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, stall watchdog limit, legal range 2..255; used only when the macro in REQ-024 is defined.
REQ-004 clk  in  1  single clock; all logic is on posedge clk.
REQ-005 aresetn  in  1  reset, synchronous and active-low, sampled on posedge clk.
REQ-006 s_valid  in  NUM_SRC  per-source beat valid.
REQ-007 s_ready  out  NUM_SRC  per-source beat accept.
REQ-008 s_data  in  NUM_SRC*DATA_WIDTH  per-source payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 s_last  in  NUM_SRC  per-source end-of-packet.
REQ-010 s_drop  in  NUM_SRC  per-source discard-packet flag, sampled with s_last.
REQ-011 m_wvalid, m_wdata (DATA_WIDTH), m_wlast, m_wdrop  out  FIFO write port.
REQ-012 m_wready, m_walmost_full  in  1 each  FIFO accept and almost-full status.
REQ-013 grant  out  NUM_SRC  one-hot owner of the FIFO write port; all zero when idle.
REQ-014 busy  out  1  high while a packet is locked.

Function
REQ-015 SHALL implement FSM states IDLE and LOCK, plus FLUSH only under REQ-024.
REQ-016 IDLE: outputs m_wvalid=0 and s_ready=0. If m_walmost_full=0 and any s_valid is high, the FSM SHALL select the first requesting source in round-robin order starting at rr_ptr+1 (mod NUM_SRC), register it into grant, and enter LOCK on the next edge.
REQ-017 IDLE with m_walmost_full=1: SHALL NOT grant; requests stay pending with no loss.
REQ-018 LOCK: m_wvalid, m_wdata, m_wlast and m_wdrop SHALL be combinational copies of the granted source's signals. s_ready[g] SHALL equal m_wready. All other s_ready bits SHALL be 0.
REQ-019 LOCK: m_walmost_full SHALL be ignored. A started packet is never interrupted.
REQ-020 LOCK: a handshake (m_wvalid & m_wready) with s_last[g]=1 SHALL set rr_ptr=g, clear grant and enter IDLE on that edge. Every packet, including single-beat packets, therefore costs one IDLE bubble cycle.
REQ-021 s_drop of a non-last beat SHALL be passed through unchanged. The arbiter never interprets it.
REQ-022 A source deasserting s_valid mid-packet SHALL keep the lock. Without REQ-024 the lock is held indefinitely.

Reset
REQ-023 With aresetn=0 at a posedge: state=IDLE, grant=0, busy=0, rr_ptr=NUM_SRC-1 (source 0 wins first), watchdog count=0, timeout=0. This applies mid-packet and discards the lock. Combinational outputs then read m_wvalid=0 and s_ready=0.

Configuration
REQ-024 Macro HS_FIFO_PKT_ARB_TIMEOUT_EN:
- Defined: output port timeout (NUM_SRC, out) exists.
- In LOCK, a counter SHALL count consecutive cycles with s_valid[g]=0 and reset on any s_valid[g]=1.
- When the counter reaches TIMEOUT_CYCLES, the FSM SHALL enter FLUSH.
- FLUSH: drive m_wvalid=1, m_wdata=0, m_wlast=1, m_wdrop=1, s_ready=0.
- On m_wready, FLUSH SHALL pulse timeout[g] for 1 cycle, set rr_ptr=g and enter IDLE.
REQ-025 Macro undefined: no timeout port, no counter, no FLUSH state. Behaviour is REQ-022.

Structure
REQ-026 Package hs_fifo_pkt_arb_pkg SHALL hold the FSM state enum and the rr_ptr width constant ($clog2 of the maximum NUM_SRC).
REQ-027 Sub-module hs_fifo_rr_pick SHALL be combinational: inputs request vector and rr_ptr; outputs one-hot winner and any-request flag.

Verification
REQ-028 NUM_SRC=4; sources 0..3 each send a 2-beat packet at once; m_wready=1 -> packets granted in order 0,1,2,3, each 3 cycles, beats never interleaved.
REQ-029 Source 2 is locked; source 1 requests; m_walmost_full rises mid-packet -> source 2 completes its packet; no grant to 1 until m_walmost_full=0.
REQ-030 m_wready toggles 1,0,1,0 during a 4-beat packet -> m_wdata is stable while m_wvalid=1 and m_wready=0; exactly 4 beats are written.
REQ-031 aresetn=0 for 1 cycle during beat 2 of 4 from source 3 -> grant=0, busy=0 the next cycle; then source 0 wins over source 3 when both request.
REQ-032 Macro defined, TIMEOUT_CYCLES=16; source 1 stalls after beat 1 -> after 16 idle cycles one beat is written with wlast=1, wdrop=1, data 0; timeout[1] pulses; source 2 is granted next.
REQ-033 Single-beat packets from sources 0 and 1 continuously -> alternating grants; throughput is 1 beat per 2 cycles.
